// File: rtl/diannao_node_seq.sv
// diannao_node_seq: layer sequencer for a DianNao-style node.
// It walks the (input block, output block) tile space and issues one NBin
// address per synapse tile. The matching accumulate and NBout write-back
// controls come out PIPE_LAT cycles later through a tracking shift register.
// That register is never stalled, so a synapse-buffer bubble travels down it
// as an invalid entry.
module diannao_node_seq #(
    parameter int ADDR_WIDTH = 6,
    parameter int PIPE_LAT   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_in_blks_m1,
    input  logic [ADDR_WIDTH-1:0] i_out_blks_m1,
    input  logic                  i_sigmoid_en,
    input  logic                  i_sb_valid,
    output logic                  o_sb_rd,
    output logic [ADDR_WIDTH-1:0] o_nbin_addr,
    output logic                  o_acc_en,
    output logic                  o_acc_first,
    output logic                  o_nbout_wen,
    output logic [ADDR_WIDTH-1:0] o_nbout_addr,
    output logic                  o_nbout_nfu2_nfu3,
    output logic                  o_busy,
    output logic                  o_done
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   in_cnt_q, in_cnt_d;
    logic [ADDR_WIDTH-1:0]   out_cnt_q, out_cnt_d;
    logic [ADDR_WIDTH-1:0]   in_m1_q, in_m1_d;
    logic [ADDR_WIDTH-1:0]   out_m1_q, out_m1_d;
    logic                    sig_q, sig_d;

    // Tracking pipe. Fields are zeroed when an entry is invalid, so the tail
    // flops can drive the outputs directly with no extra masking.
    logic [PIPE_LAT-1:0]                 vld_q, vld_d;
    logic [PIPE_LAT-1:0]                 first_q, first_d;
    logic [PIPE_LAT-1:0]                 last_q, last_d;
    logic [PIPE_LAT-1:0]                 nfu3_q, nfu3_d;
    logic [PIPE_LAT-1:0][ADDR_WIDTH-1:0] addr_q, addr_d;

    logic issue;
    logic in_wrap;
    logic pend;

    assign issue   = (state_q == S_ISSUE) && i_sb_valid;
    assign in_wrap = (in_cnt_q == in_m1_q);
    // Work is still pending if any entry remains after this edge. When the
    // last entry sits at the tail, DONE follows right after its write.
    assign pend    = |vld_d;

    // Next-state logic, counters and config latch
    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        in_m1_d   = in_m1_q;
        out_m1_d  = out_m1_q;
        sig_d     = sig_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    in_m1_d   = i_in_blks_m1;
                    out_m1_d  = i_out_blks_m1;
                    sig_d     = i_sigmoid_en;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue) begin
                    if (in_wrap) begin
                        in_cnt_d  = '0;
                        out_cnt_d = out_cnt_q + ADDR_WIDTH'(1);
                        if (out_cnt_q == out_m1_q) state_d = S_DRAIN;
                    end else begin
                        in_cnt_d = in_cnt_q + ADDR_WIDTH'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (!pend) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Shift the tracking pipe by one stage and insert the entry for this cycle at the head
    always_comb begin
        vld_d      = '0;
        first_d    = '0;
        last_d     = '0;
        nfu3_d     = '0;
        addr_d     = '0;
        vld_d[0]   = issue;
        first_d[0] = issue && (in_cnt_q == '0);
        last_d[0]  = issue && in_wrap;
        nfu3_d[0]  = issue && in_wrap && sig_q;
        addr_d[0]  = issue ? out_cnt_q : '0;
        for (int k = 1; k < PIPE_LAT; k++) begin
            vld_d[k]   = vld_q[k-1];
            first_d[k] = first_q[k-1];
            last_d[k]  = last_q[k-1];
            nfu3_d[k]  = nfu3_q[k-1];
            addr_d[k]  = addr_q[k-1];
        end
    end

    // State, counter, config and pipe registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            in_m1_q   <= '0;
            out_m1_q  <= '0;
            sig_q     <= 1'b0;
            vld_q     <= '0;
            first_q   <= '0;
            last_q    <= '0;
            nfu3_q    <= '0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            in_m1_q   <= in_m1_d;
            out_m1_q  <= out_m1_d;
            sig_q     <= sig_d;
            vld_q     <= vld_d;
            first_q   <= first_d;
            last_q    <= last_d;
            nfu3_q    <= nfu3_d;
            addr_q    <= addr_d;
        end
    end

    assign o_sb_rd           = issue;
    assign o_nbin_addr       = (state_q == S_ISSUE) ? in_cnt_q : '0;
    assign o_acc_en          = vld_q[PIPE_LAT-1];
    assign o_acc_first       = first_q[PIPE_LAT-1];
    assign o_nbout_wen       = last_q[PIPE_LAT-1];
    assign o_nbout_addr      = addr_q[PIPE_LAT-1];
    assign o_nbout_nfu2_nfu3 = nfu3_q[PIPE_LAT-1];
    assign o_busy            = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign o_done            = (state_q == S_DONE);

endmodule

// File: tb/tb_diannao_node_seq.sv
// Bench for diannao_node_seq. Each issue cycle pushes the tail entry expected
// PIPE_LAT cycles later onto a scoreboard queue. Every cycle, the bench compares
// the whole output vector against the model.
module tb_diannao_node_seq;
    localparam int AW = 6;
    localparam int P  = 5;
    localparam int W  = 2 * AW + 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_start = 1'b0;
    logic [AW-1:0] i_in_blks_m1 = '0;
    logic [AW-1:0] i_out_blks_m1 = '0;
    logic          i_sigmoid_en = 1'b0;
    logic          i_sb_valid = 1'b0;
    logic          o_sb_rd, o_acc_en, o_acc_first, o_nbout_wen;
    logic          o_nbout_nfu2_nfu3, o_busy, o_done;
    logic [AW-1:0] o_nbin_addr, o_nbout_addr;

    typedef struct {
        int            due;
        logic          first;
        logic          last;
        logic          nfu3;
        logic [AW-1:0] addr;
    } ent_t;

    ent_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    diannao_node_seq #(.ADDR_WIDTH(AW), .PIPE_LAT(P)) dut (
        .clk(clk), .rst(rst), .i_start(i_start),
        .i_in_blks_m1(i_in_blks_m1), .i_out_blks_m1(i_out_blks_m1),
        .i_sigmoid_en(i_sigmoid_en), .i_sb_valid(i_sb_valid),
        .o_sb_rd(o_sb_rd), .o_nbin_addr(o_nbin_addr), .o_acc_en(o_acc_en),
        .o_acc_first(o_acc_first), .o_nbout_wen(o_nbout_wen),
        .o_nbout_addr(o_nbout_addr), .o_nbout_nfu2_nfu3(o_nbout_nfu2_nfu3),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] obs_vec();
        return {o_sb_rd, o_nbin_addr, o_acc_en, o_acc_first, o_nbout_wen,
                o_nbout_addr, o_nbout_nfu2_nfu3, o_busy, o_done};
    endfunction

    // One layer. ba/bb are ISSUE-phase cycle indices that see i_sb_valid low.
    // rnd makes bubbles random. poke re-pulses i_start with scrambled config
    // mid-layer. abort_t asserts rst in that cycle and ends the layer.
    task automatic run_layer(input string name, input int im, input int om, input bit sig,
                             input int ba, input int bb, input bit rnd, input bit poke,
                             input int abort_t);
        int in_c = 0, out_c = 0, last_t = -1, k = 0, acc = 0, wr = 0, ndone = 0, limit;
        bit issuing = 1'b1, sbv, done_seen = 1'b0;
        logic          x_rd, x_acc, x_first, x_wen, x_nfu3, x_busy, x_done;
        logic [AW-1:0] x_addr, x_oaddr;
        ent_t e;
        exp_q.delete();
        limit = (im + 1) * (om + 1) * 4 + P + 20;
        i_in_blks_m1  = AW'(im);
        i_out_blks_m1 = AW'(om);
        i_sigmoid_en  = sig;
        i_sb_valid    = 1'b0;
        i_start       = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        for (int t = 1; t <= limit && !done_seen; t++) begin
            if (issuing) begin
                sbv = rnd ? ($urandom_range(0, 3) != 0) : !(k == ba || k == bb);
                k++;
            end else begin
                sbv = 1'($urandom_range(0, 1));
            end
            i_sb_valid = sbv;
            if (poke && t == 3) begin
                i_start       = 1'b1;
                i_in_blks_m1  = AW'($urandom);
                i_out_blks_m1 = AW'($urandom);
                i_sigmoid_en  = ~sig;
            end
            if (poke && t == 4) i_start = 1'b0;
            if (t == abort_t) begin
                rst = 1'b1;
                @(negedge clk);
                chk({name, "/reset_outputs"}, 64'(obs_vec()), 64'(0));
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            x_rd = 1'b0; x_addr = '0; x_acc = 1'b0; x_first = 1'b0;
            x_wen = 1'b0; x_oaddr = '0; x_nfu3 = 1'b0;
            if (issuing) begin
                x_rd   = sbv;
                x_addr = AW'(in_c);
                if (sbv) begin
                    e.due   = t + P;
                    e.first = (in_c == 0);
                    e.last  = (in_c == im);
                    e.nfu3  = (in_c == im) && sig;
                    e.addr  = AW'(out_c);
                    exp_q.push_back(e);
                    if (in_c == im) begin
                        in_c = 0;
                        if (out_c == om) begin
                            issuing = 1'b0;
                            last_t  = t;
                        end
                        out_c++;
                    end else begin
                        in_c++;
                    end
                end
            end
            if (exp_q.size() > 0 && exp_q[0].due == t) begin
                e       = exp_q.pop_front();
                x_acc   = 1'b1;
                x_first = e.first;
                x_wen   = e.last;
                x_oaddr = e.addr;
                x_nfu3  = e.nfu3;
                acc++;
                if (e.last) wr++;
            end
            x_done = (last_t >= 0) && (t == last_t + P + 1);
            x_busy = !x_done && ((last_t < 0) || (t <= last_t + P));
            @(negedge clk);
            chk({name, "/cycle"}, 64'(obs_vec()),
                64'({x_rd, x_addr, x_acc, x_first, x_wen, x_oaddr, x_nfu3, x_busy, x_done}));
            if (o_done) ndone++;
            if (x_done) done_seen = 1'b1;
            @(posedge clk); #1;
        end
        chk({name, "/done_seen"}, 64'(done_seen), 64'(1));
        chk({name, "/done_count"}, 64'(ndone), 64'(1));
        chk({name, "/acc_pulses"}, 64'(acc), 64'((im + 1) * (om + 1)));
        chk({name, "/writes"}, 64'(wr), 64'(om + 1));
        chk({name, "/queue_empty"}, 64'(exp_q.size()), 64'(0));
        // Back in IDLE: a valid synapse tile must not be consumed.
        i_sb_valid = 1'b1;
        @(negedge clk);
        chk({name, "/idle_after"}, 64'(obs_vec()), 64'(0));
        @(posedge clk); #1;
    endtask

    task automatic idle_check(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            i_sb_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk(name, 64'(obs_vec()), 64'(0));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_state", 64'(obs_vec()), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        idle_check("idle", 2);
        run_layer("basic",     3, 1, 1'b0, -1, -1, 1'b0, 1'b0, -1);
        run_layer("bubbles",   3, 1, 1'b1,  2,  5, 1'b0, 1'b0, -1);
        run_layer("single",    0, 0, 1'b0, -1, -1, 1'b0, 1'b0, -1);
        run_layer("in_m1_0",   0, 3, 1'b1,  1, -1, 1'b0, 1'b0, -1);
        // Issue index 6 holds in_cnt=2, out_cnt=1; it runs in cycle 7.
        run_layer("abort",     3, 1, 1'b0, -1, -1, 1'b0, 1'b0, 7);
        idle_check("post_abort", P + 3);
        run_layer("restart",   3, 1, 1'b0, -1, -1, 1'b0, 1'b0, -1);
        run_layer("restart_ignored", 2, 2, 1'b0, -1, -1, 1'b0, 1'b1, -1);
        run_layer("random_bub", 4, 3, 1'b1, -1, -1, 1'b1, 1'b0, -1);
        run_layer("max",      63, 63, 1'b0, -1, -1, 1'b0, 1'b0, -1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
